// File: rtl/command_word_sequencer.sv
// 8259A bus-write front end: captures CPU writes, tracks the ICW1..ICW4 init
// sequence and issues one-cycle ICW/OCW write strobes. Optional: CMD_SEQ_ERROR_FLAG_EN.
module command_word_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       chip_select_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1_registers,
  output logic       write_operation_control_word_2_registers,
  output logic       write_operation_control_word_3_registers,
`ifdef CMD_SEQ_ERROR_FLAG_EN
  output logic       sequence_error,
`endif
  output logic       init_busy
);

  typedef enum logic [2:0] {
    S_WAIT_ICW1,
    S_ICW2,
    S_ICW3,
    S_ICW4,
    S_READY
  } state_t;

  // Strobe vector bit positions.
  localparam int ST_ICW1 = 0;
  localparam int ST_ICW2 = 1;
  localparam int ST_ICW3 = 2;
  localparam int ST_ICW4 = 3;
  localparam int ST_OCW1 = 4;
  localparam int ST_OCW2 = 5;
  localparam int ST_OCW3 = 6;

  state_t     state;
  state_t     state_next;
  logic       addr_q;
  logic       cs_q;
  logic       wr_n_q;
  logic       armed;
  logic       capture;
  logic       write_end;
  logic       single;
  logic       single_next;
  logic       ic4;
  logic       ic4_next;
  logic [6:0] strobe_p1;
  logic [6:0] strobe_next;

  // A reset during a low write phase must not let that same phase be
  // re-captured, so capture is held off until write_enable_n is seen high.
  assign capture   = armed && !chip_select_n && !write_enable_n;
  assign write_end = cs_q && !wr_n_q && write_enable_n;

  // Stage p0: bus write capture
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      internal_data_bus <= 8'h00;
      addr_q            <= 1'b0;
      cs_q              <= 1'b0;
      wr_n_q            <= 1'b1;
      armed             <= 1'b0;
    end else begin
      wr_n_q <= write_enable_n;
      if (write_enable_n) begin
        armed <= 1'b1;
      end
      if (capture) begin
        internal_data_bus <= data_bus_in;
        addr_q            <= address;
        cs_q              <= 1'b1;
      end else if (write_end) begin
        cs_q <= 1'b0;
      end
    end
  end

  // Decode of the completed write; ICW1 overrides whatever state we are in.
  always_comb begin
    state_next  = state;
    single_next = single;
    ic4_next    = ic4;
    strobe_next = '0;
    if (write_end) begin
      if (!addr_q && internal_data_bus[4]) begin
        strobe_next[ST_ICW1] = 1'b1;
        single_next          = internal_data_bus[1];
        ic4_next             = internal_data_bus[0];
        state_next           = S_ICW2;
      end else begin
        case (state)
          S_ICW2: begin
            if (addr_q) begin
              strobe_next[ST_ICW2] = 1'b1;
              if (!single) begin
                state_next = S_ICW3;
              end else if (ic4) begin
                state_next = S_ICW4;
              end else begin
                state_next = S_READY;
              end
            end
          end
          S_ICW3: begin
            if (addr_q) begin
              strobe_next[ST_ICW3] = 1'b1;
              state_next           = ic4 ? S_ICW4 : S_READY;
            end
          end
          S_ICW4: begin
            if (addr_q) begin
              strobe_next[ST_ICW4] = 1'b1;
              state_next           = S_READY;
            end
          end
          S_READY: begin
            if (addr_q) begin
              strobe_next[ST_OCW1] = 1'b1;
            end else if (internal_data_bus[3]) begin
              strobe_next[ST_OCW3] = 1'b1;
            end else begin
              strobe_next[ST_OCW2] = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Stage p1: registered strobes and sequence state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_WAIT_ICW1;
      single    <= 1'b0;
      ic4       <= 1'b0;
      strobe_p1 <= '0;
    end else begin
      state     <= state_next;
      single    <= single_next;
      ic4       <= ic4_next;
      strobe_p1 <= strobe_next;
    end
  end

`ifdef CMD_SEQ_ERROR_FLAG_EN
  // Every completed write either strobes or is ignored.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sequence_error <= 1'b0;
    end else if (strobe_next[ST_ICW1]) begin
      sequence_error <= 1'b0;
    end else if (write_end && (strobe_next == '0)) begin
      sequence_error <= 1'b1;
    end
  end
`endif

  assign write_initial_command_word_1             = strobe_p1[ST_ICW1];
  assign write_initial_command_word_2             = strobe_p1[ST_ICW2];
  assign write_initial_command_word_3             = strobe_p1[ST_ICW3];
  assign write_initial_command_word_4             = strobe_p1[ST_ICW4];
  assign write_operation_control_word_1_registers = strobe_p1[ST_OCW1];
  assign write_operation_control_word_2_registers = strobe_p1[ST_OCW2];
  assign write_operation_control_word_3_registers = strobe_p1[ST_OCW3];

  assign init_busy = (state == S_ICW2) || (state == S_ICW3) || (state == S_ICW4);

endmodule

// File: tb/tb_command_word_sequencer.sv
// Scoreboard bench for command_word_sequencer: each write pushes its expected
// strobe, bus byte, busy level and arrival cycle; a monitor pops and compares.
module tb_command_word_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       chip_select_n;
  logic       write_enable_n;
  logic       address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;
  logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
  logic       init_busy;
`ifdef CMD_SEQ_ERROR_FLAG_EN
  logic       sequence_error;
`endif
  logic [6:0] strobes;

  command_word_sequencer dut (
    .clock                                    (clock),
    .reset_n                                  (reset_n),
    .chip_select_n                            (chip_select_n),
    .write_enable_n                           (write_enable_n),
    .address                                  (address),
    .data_bus_in                              (data_bus_in),
    .internal_data_bus                        (internal_data_bus),
    .write_initial_command_word_1             (icw1),
    .write_initial_command_word_2             (icw2),
    .write_initial_command_word_3             (icw3),
    .write_initial_command_word_4             (icw4),
    .write_operation_control_word_1_registers (ocw1),
    .write_operation_control_word_2_registers (ocw2),
    .write_operation_control_word_3_registers (ocw3),
`ifdef CMD_SEQ_ERROR_FLAG_EN
    .sequence_error                           (sequence_error),
`endif
    .init_busy                                (init_busy)
  );

  assign strobes = {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] strobe;
    logic [7:0] data;
    logic       busy;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cycle = 0;

  // Reference sequence model: 0 wait-ICW1, 1 ICW2, 2 ICW3, 3 ICW4, 4 ready.
  int   m_st     = 0;
  bit   m_single = 1'b0;
  bit   m_ic4    = 1'b0;
  bit   m_err    = 1'b0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic bit model_busy();
    return (m_st >= 1) && (m_st <= 3);
  endfunction

  task automatic model_write(input bit a, input logic [7:0] d, output logic [6:0] s);
    s = 7'h00;
    if (!a && d[4]) begin
      m_single = d[1];
      m_ic4    = d[0];
      m_st     = 1;
      m_err    = 1'b0;
      s        = 7'h01;
    end else begin
      case (m_st)
        1: if (a) begin s = 7'h02; m_st = !m_single ? 2 : (m_ic4 ? 3 : 4); end
        2: if (a) begin s = 7'h04; m_st = m_ic4 ? 3 : 4; end
        3: if (a) begin s = 7'h08; m_st = 4; end
        4: s = a ? 7'h10 : (d[3] ? 7'h40 : 7'h20);
        default: ;
      endcase
      if (s == 7'h00) m_err = 1'b1;
    end
  endtask

  // Monitor: any strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    if (strobes !== 7'h00) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_strobe", {25'd0, strobes}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("strobe", {25'd0, strobes}, {25'd0, e.strobe});
        check_eq("bus", {24'd0, internal_data_bus}, {24'd0, e.data});
        check_eq("busy_at_strobe", {31'd0, init_busy}, {31'd0, e.busy});
        check_eq("strobe_cycle", cycle, e.cyc);
      end
    end
  end

  task automatic wr(input bit a, input logic [7:0] d, input int hold = 1, input bit early_cs = 1'b0);
    logic [6:0] s;
    int         last;
    exp_t       e;
    model_write(a, d, s);
    @(posedge clock); #1;
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = a;
    data_bus_in    = d;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (early_cs) chip_select_n = 1'b1;
    end
    last           = cycle;
    write_enable_n = 1'b1;
    chip_select_n  = 1'b1;
    if (s != 7'h00) begin
      e.strobe = s;
      e.data   = d;
      e.busy   = model_busy();
      e.cyc    = last + 1;
      sb.push_back(e);
    end
    repeat (3) @(posedge clock);
    #1;
    check_eq("busy_after_write", {31'd0, init_busy}, {31'd0, model_busy()});
`ifdef CMD_SEQ_ERROR_FLAG_EN
    check_eq("sequence_error", {31'd0, sequence_error}, {31'd0, m_err});
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clock);
    check_eq({tag, "_bus"}, {24'd0, internal_data_bus}, 32'h0);
    check_eq({tag, "_strobes"}, {25'd0, strobes}, 32'h0);
    check_eq({tag, "_busy"}, {31'd0, init_busy}, 32'h0);
`ifdef CMD_SEQ_ERROR_FLAG_EN
    check_eq({tag, "_seqerr"}, {31'd0, sequence_error}, 32'h0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    address        = 1'b0;
    data_bus_in    = 8'h00;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    check_reset_outputs("reset");

    // OCW3 before init is ignored
    wr(1'b0, 8'h0A);

    // Single, ic4: ICW1, ICW2, ICW4
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h20);
    wr(1'b1, 8'h01);

    // Cascade, ic4: all four ICWs
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h20);
    wr(1'b1, 8'h04);
    wr(1'b1, 8'h01);

    // Operational words
    wr(1'b1, 8'hFF);
    wr(1'b0, 8'h20);
    wr(1'b0, 8'h0B);
    wr(1'b0, 8'h68);
    wr(1'b1, 8'hA5, 3, 1'b1);

    // Restart from S_ICW3, then an ignored write mid-sequence
    wr(1'b0, 8'h10);
    wr(1'b1, 8'h30);
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h40);
    wr(1'b0, 8'h05);
    wr(1'b1, 8'h02, 2);
    wr(1'b1, 8'h1D);

    // Reset during a low write phase
    @(posedge clock); #1;
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = 1'b1;
    data_bus_in    = 8'hAA;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n  = 1'b1;
    m_st     = 0;
    m_single = 1'b0;
    m_ic4    = 1'b0;
    m_err    = 1'b0;
    check_reset_outputs("midwrite_reset");
    @(posedge clock); #1;
    write_enable_n = 1'b1;
    chip_select_n  = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check_eq("post_reset_busy", {31'd0, init_busy}, 32'h0);

    // Single, no ic4: ICW2 goes straight to ready
    wr(1'b0, 8'h12);
    wr(1'b1, 8'h08);
    wr(1'b0, 8'h60);
    wr(1'b1, 8'h3C);

    repeat (4) @(posedge clock);
    #1;
    check_eq("pending_expectations", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
